// File: rtl/vga_timing_gen_if.sv
// Timing bus between the VGA timing generator and the pixel pipeline.
// Carries the mouse position in and the aligned counters/flags out.
interface vga_timing_gen_if;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hblnk;
  logic        vblnk;
  logic        hsync;
  logic        vsync;
  logic        frame_start;
  logic [11:0] xpos_out;
  logic [11:0] ypos_out;

  modport master (
    input  xpos, ypos,
    output hcount, vcount,
    output hblnk, vblnk,
    output hsync, vsync,
    output frame_start,
    output xpos_out, ypos_out
  );

  modport slave (
    output xpos, ypos,
    input  hcount, vcount,
    input  hblnk, vblnk,
    input  hsync, vsync,
    input  frame_start,
    input  xpos_out, ypos_out
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA counter/sync generator with registered outputs.
// VGA_POS_LATCH_EN: hold mouse position for a whole frame.
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23
) (
  input logic clk,
  input logic rst,
  vga_timing_gen_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] HB_ON  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_ON  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_OFF = 11'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] VB_ON  = 10'(V_ACTIVE);
  localparam logic [9:0] VS_ON  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_OFF = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] h_nxt;
  logic [9:0]  v_nxt;
  logic        h_wrap;
  logic        fs_nxt;

  // Flags are decoded from the next counts so they land with them.
  always_comb begin
    h_wrap = bus.hcount >= H_LAST;
    h_nxt  = h_wrap ? 11'd0 : bus.hcount + 11'd1;
    v_nxt  = bus.vcount;
    if (h_wrap) begin
      v_nxt = (bus.vcount >= V_LAST) ? 10'd0
                                     : bus.vcount + 10'd1;
    end
    fs_nxt = (h_nxt == 11'd0) && (v_nxt == 10'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.hcount      <= '0;
      bus.vcount      <= '0;
      bus.hblnk       <= 1'b0;
      bus.vblnk       <= 1'b0;
      bus.hsync       <= 1'b0;
      bus.vsync       <= 1'b0;
      bus.frame_start <= 1'b0;
    end else begin
      bus.hcount      <= h_nxt;
      bus.vcount      <= v_nxt;
      bus.hblnk       <= h_nxt >= HB_ON;
      bus.vblnk       <= v_nxt >= VB_ON;
      bus.hsync       <= (h_nxt >= HS_ON) && (h_nxt < HS_OFF);
      bus.vsync       <= (v_nxt >= VS_ON) && (v_nxt < VS_OFF);
      bus.frame_start <= fs_nxt;
    end
  end

`ifdef VGA_POS_LATCH_EN
  always_ff @(posedge clk) begin
    if (rst || fs_nxt) begin
      bus.xpos_out <= bus.xpos;
      bus.ypos_out <= bus.ypos;
    end
  end
`else
  always_ff @(posedge clk) begin
    bus.xpos_out <= bus.xpos;
    bus.ypos_out <= bus.ypos;
  end
`endif
endmodule
